// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: hazard sequencer state and per-register control bundles.
package cpu_types_pkg;

  localparam int unsigned RegAddrW = 5;

  // Hazard sequencer state. HALT is only left through reset.
  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDwait = 2'd1,
    StHalt  = 2'd2
  } hazard_state_t;

  // Write enables for the PC and the four pipeline registers.
  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } pipe_wen_t;

  // Bubble inserts; a flush overrides the matching write enable at the register.
  typedef struct packed {
    logic ifid;
    logic idex;
    logic exmem;
  } pipe_flush_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, else increment unless already all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: derives PC / pipeline-register enables and flushes each
// cycle from cache handshakes, load-use hazards, redirects and halt.
module pipe_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                ihit,
  input  logic                dhit,
  input  logic                exmem_MemRead,
  input  logic                exmem_MemWrite,
  input  logic                idex_MemRead,
  input  logic [RegAddrW-1:0] idex_rt,
  input  logic [RegAddrW-1:0] ifid_rs,
  input  logic [RegAddrW-1:0] ifid_rt,
  input  logic                branch_taken,
  input  logic                jump_ex,
  input  logic                halt_wb,
  input  logic                clr_perf,
  output logic                pc_WEN,
  output logic                ifid_WEN,
  output logic                idex_WEN,
  output logic                exmem_WEN,
  output logic                memwb_WEN,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic                exmem_flush,
  output logic                dmem_wait,
  output logic                halted,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  hazard_state_t state_q, state_d;
  pipe_wen_t     wen;
  pipe_flush_t   flush;
  logic          dpend;
  logic          load_use;
  logic          redirect;
  logic          stall_inc;

  // Data access outstanding in MEM: freeze the whole pipe until dhit.
  assign dpend = (exmem_MemRead | exmem_MemWrite) & ~dhit;

  // Load in EX writes a register the instruction in ID reads ($0 never hazards).
  assign load_use = idex_MemRead & (idex_rt != '0) &
                    ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: halt is sticky, otherwise track whether a data access is pending.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun, StDwait: begin
        if (halt_wb) begin
          state_d = StHalt;
        end else if (dpend) begin
          state_d = StDwait;
        end else begin
          state_d = StRun;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  // Control outputs: first matching rule wins; redirects beat load-use and fetch miss.
  always_comb begin
    wen      = '1;
    flush    = '0;
    redirect = 1'b0;
    if ((state_q == StHalt) || halt_wb || dpend) begin
      wen = '0;
    end else if (branch_taken) begin
      flush    = '{ifid: 1'b1, idex: 1'b1, exmem: 1'b1};
      redirect = 1'b1;
    end else if (jump_ex) begin
      flush.ifid = 1'b1;
      flush.idex = 1'b1;
      redirect   = 1'b1;
    end else if (load_use) begin
      wen.pc     = 1'b0;
      wen.ifid   = 1'b0;
      flush.idex = 1'b1;
    end else if (!ihit) begin
      wen.pc     = 1'b0;
      flush.ifid = 1'b1;
    end
  end

  assign pc_WEN      = wen.pc;
  assign ifid_WEN    = wen.ifid;
  assign idex_WEN    = wen.idex;
  assign exmem_WEN   = wen.exmem;
  assign memwb_WEN   = wen.memwb;
  assign ifid_flush  = flush.ifid;
  assign idex_flush  = flush.idex;
  assign exmem_flush = flush.exmem;

  assign dmem_wait = (state_q == StDwait);
  assign halted    = (state_q == StHalt);

  // A held PC while halted is not a stall.
  assign stall_inc = ~wen.pc & (state_q != StHalt);

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (stall_inc),
    .clr  (clr_perf),
    .cnt  (stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (redirect),
    .clr  (clr_perf),
    .cnt  (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a rule-table model checked every cycle
// against a 32-bit and a 4-bit counter build, plus directed literal expectations.
module tb_pipe_hazard_ctrl;

  logic       CLK;
  logic       nRST;
  logic       ihit, dhit, exmem_MemRead, exmem_MemWrite, idex_MemRead;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       branch_taken, jump_ex, halt_wb, clr_perf;

  logic pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN;
  logic ifid_flush, idex_flush, exmem_flush, dmem_wait, halted;
  logic [31:0] stall_cnt, flush_cnt;

  logic pc_WEN4, ifid_WEN4, idex_WEN4, exmem_WEN4, memwb_WEN4;
  logic ifid_flush4, idex_flush4, exmem_flush4, dmem_wait4, halted4;
  logic [3:0] stall_cnt4, flush_cnt4;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  pipe_hazard_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
    .idex_MemRead(idex_MemRead), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .jump_ex(jump_ex), .halt_wb(halt_wb), .clr_perf(clr_perf),
    .pc_WEN(pc_WEN), .ifid_WEN(ifid_WEN), .idex_WEN(idex_WEN), .exmem_WEN(exmem_WEN),
    .memwb_WEN(memwb_WEN), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .dmem_wait(dmem_wait), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
    .idex_MemRead(idex_MemRead), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .jump_ex(jump_ex), .halt_wb(halt_wb), .clr_perf(clr_perf),
    .pc_WEN(pc_WEN4), .ifid_WEN(ifid_WEN4), .idex_WEN(idex_WEN4), .exmem_WEN(exmem_WEN4),
    .memwb_WEN(memwb_WEN4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
    .exmem_flush(exmem_flush4), .dmem_wait(dmem_wait4), .halted(halted4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Outputs packed as {pc, ifid, idex, exmem, memwb WEN, ifid, idex, exmem flush}.
  wire [7:0] ctrl  = {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN,
                      ifid_flush, idex_flush, exmem_flush};
  wire [7:0] ctrl4 = {pc_WEN4, ifid_WEN4, idex_WEN4, exmem_WEN4, memwb_WEN4,
                      ifid_flush4, idex_flush4, exmem_flush4};

  // ---------------- behavioural model ----------------
  bit          m_halted, m_dwait;
  logic [31:0] m_stall32, m_flush32;
  int          m_stall4, m_flush4;

  // Rule table; returns {redirect, ctrl[7:0]}.
  function automatic logic [8:0] rules(input bit hlt, input bit hw, input bit dp,
                                       input bit br, input bit jp, input bit lu, input bit ih);
    if (hlt || hw || dp) return {1'b0, 8'b00000_000};
    if (br)              return {1'b1, 8'b11111_111};
    if (jp)              return {1'b1, 8'b11111_110};
    if (lu)              return {1'b0, 8'b00111_010};
    if (!ih)             return {1'b0, 8'b01111_100};
    return {1'b0, 8'b11111_000};
  endfunction

  wire m_dpend = (exmem_MemRead || exmem_MemWrite) && !dhit;
  wire m_lu    = idex_MemRead && (idex_rt != 5'd0) &&
                 ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  wire [8:0] m_now = rules(m_halted, halt_wb, m_dpend, branch_taken, jump_ex, m_lu, ihit);
  wire m_stall_inc = !m_now[7] && !m_halted;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_halted  <= 1'b0;
      m_dwait   <= 1'b0;
      m_stall32 <= 32'd0;
      m_flush32 <= 32'd0;
      m_stall4  <= 0;
      m_flush4  <= 0;
    end else begin
      if (!m_halted) begin
        m_halted <= halt_wb;
        m_dwait  <= !halt_wb && m_dpend;
      end
      m_stall32 <= clr_perf ? 32'd0 :
                   (m_stall_inc && m_stall32 != 32'hFFFF_FFFF) ? m_stall32 + 32'd1 : m_stall32;
      m_flush32 <= clr_perf ? 32'd0 :
                   (m_now[8] && m_flush32 != 32'hFFFF_FFFF) ? m_flush32 + 32'd1 : m_flush32;
      m_stall4  <= clr_perf ? 0 : (m_stall_inc && m_stall4 < 15) ? m_stall4 + 1 : m_stall4;
      m_flush4  <= clr_perf ? 0 : (m_now[8] && m_flush4 < 15) ? m_flush4 + 1 : m_flush4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_ctrl", {24'd0, ctrl}, {24'd0, m_now[7:0]});
      check("model_ctrl4", {24'd0, ctrl4}, {24'd0, m_now[7:0]});
      check("model_dmem_wait", {31'd0, dmem_wait}, {31'd0, m_dwait});
      check("model_halted", {31'd0, halted}, {31'd0, m_halted});
      check("model_halted4", {31'd0, halted4}, {31'd0, m_halted});
      check("model_stall_cnt", stall_cnt, m_stall32);
      check("model_flush_cnt", flush_cnt, m_flush32);
      check("model_stall_cnt4", {28'd0, stall_cnt4}, m_stall4);
      check("model_flush_cnt4", {28'd0, flush_cnt4}, m_flush4);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    ihit = 1'b1; dhit = 1'b1; exmem_MemRead = 1'b0; exmem_MemWrite = 1'b0;
    idex_MemRead = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    branch_taken = 1'b0; jump_ex = 1'b0; halt_wb = 1'b0; clr_perf = 1'b0;
  endtask

  typedef struct {
    logic       mw;
    logic       dh;
    logic       br;
    logic       jp;
    logic       lu;
    logic       ih;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{mw: 1, dh: 0, br: 1, jp: 0, lu: 0, ih: 1, exp: 8'b00000_000};
    vecs[1] = '{mw: 1, dh: 1, br: 1, jp: 0, lu: 0, ih: 1, exp: 8'b11111_111};
    vecs[2] = '{mw: 0, dh: 1, br: 0, jp: 1, lu: 1, ih: 1, exp: 8'b11111_110};
    vecs[3] = '{mw: 0, dh: 1, br: 0, jp: 0, lu: 1, ih: 0, exp: 8'b00111_010};
    vecs[4] = '{mw: 0, dh: 1, br: 0, jp: 0, lu: 0, ih: 1, exp: 8'b11111_000};

    nRST = 1'b0;
    quiet();
    chk_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_flush_cnt", flush_cnt, 32'd0);
    check("reset_dmem_wait", {31'd0, dmem_wait}, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    nRST = 1'b1;

    // Idle pipe
    #1 check("idle_ctrl", {24'd0, ctrl}, 32'h0000_00F8);
    check("idle_stall", stall_cnt, 32'd0);
    tick();

    // Load-use via rs
    idex_MemRead = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    #1 check("lu_rs_ctrl", {24'd0, ctrl}, 32'h0000_003A);
    tick();
    idex_MemRead = 1'b0;
    #1 check("lu_rs_stall", stall_cnt, 32'd1);
    check("lu_clear_ctrl", {24'd0, ctrl}, 32'h0000_00F8);
    tick();

    // Load to $0 never hazards
    idex_MemRead = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    #1 check("lu_r0_ctrl", {24'd0, ctrl}, 32'h0000_00F8);
    tick();

    // Load-use via rt
    idex_rt = 5'd7; ifid_rt = 5'd7; ifid_rs = 5'd3;
    #1 check("lu_rt_ctrl", {24'd0, ctrl}, 32'h0000_003A);
    tick();
    quiet();
    #1 check("lu_rt_stall", stall_cnt, 32'd2);

    // Fetch miss
    ihit = 1'b0;
    #1 check("imiss_ctrl", {24'd0, ctrl}, 32'h0000_007C);
    tick();
    ihit = 1'b1;
    #1 check("imiss_stall", stall_cnt, 32'd3);

    // Clear counters
    clr_perf = 1'b1;
    tick();
    clr_perf = 1'b0;
    #1 check("clr_stall", stall_cnt, 32'd0);

    // Data miss for three cycles, then dhit
    exmem_MemRead = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("dmiss_ctrl", {24'd0, ctrl}, 32'd0);
      check("dmiss_dmem_wait", {31'd0, dmem_wait}, (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    dhit = 1'b1;
    #1 check("dhit_ctrl", {24'd0, ctrl}, 32'h0000_00F8);
    check("dhit_dmem_wait", {31'd0, dmem_wait}, 32'd1);
    check("dmiss_stall", stall_cnt, 32'd3);
    tick();
    exmem_MemRead = 1'b0;
    #1 check("dmiss_exit", {31'd0, dmem_wait}, 32'd0);

    // Branch beats load-use and fetch miss
    branch_taken = 1'b1; idex_MemRead = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ihit = 1'b0;
    #1 check("branch_ctrl", {24'd0, ctrl}, 32'h0000_00FF);
    tick();
    quiet();
    #1 check("branch_flush_cnt", flush_cnt, 32'd1);
    check("branch_stall", stall_cnt, 32'd3);

    // Jump with fetch miss
    jump_ex = 1'b1; ihit = 1'b0;
    #1 check("jump_ctrl", {24'd0, ctrl}, 32'h0000_00FE);
    tick();
    quiet();
    #1 check("jump_flush_cnt", flush_cnt, 32'd2);

    // Priority table
    foreach (vecs[i]) begin
      exmem_MemWrite = vecs[i].mw; dhit = vecs[i].dh; branch_taken = vecs[i].br;
      jump_ex = vecs[i].jp; ihit = vecs[i].ih;
      idex_MemRead = vecs[i].lu; idex_rt = 5'd9; ifid_rs = 5'd9;
      #1 check("table_ctrl", {24'd0, ctrl}, {24'd0, vecs[i].exp});
      tick();
    end
    quiet();
    #1 check("table_flush_cnt", flush_cnt, 32'd4);
    check("table_stall", stall_cnt, 32'd5);

    // Halt: freezes everything and persists
    halt_wb = 1'b1;
    #1 check("halt_ctrl", {24'd0, ctrl}, 32'd0);
    check("halt_lag", {31'd0, halted}, 32'd0);
    tick();
    halt_wb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ihit = i[0]; branch_taken = i[1]; jump_ex = !i[0];
      exmem_MemRead = i[1]; dhit = i[0];
      #1 check("halted_ctrl", {24'd0, ctrl}, 32'd0);
      check("halted_flag", {31'd0, halted}, 32'd1);
      tick();
    end
    #1 check("halted_stall", stall_cnt, 32'd6);
    check("halted_flush", flush_cnt, 32'd4);

    // Reset out of HALT
    quiet();
    ihit = 1'b0;
    nRST = 1'b0;
    #1 check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_stall", stall_cnt, 32'd0);
    check("rst_flush", flush_cnt, 32'd0);
    check("rst_ctrl", {24'd0, ctrl}, 32'h0000_007C);
    tick();
    nRST = 1'b1;

    // Saturation on the 4-bit build
    repeat (20) tick();
    #1 check("sat_stall4", {28'd0, stall_cnt4}, 32'd15);
    check("sat_stall32", stall_cnt, 32'd20);
    clr_perf = 1'b1;
    tick();
    clr_perf = 1'b0;
    #1 check("clr_wins4", {28'd0, stall_cnt4}, 32'd0);
    check("clr_wins32", stall_cnt, 32'd0);
    tick();
    #1 check("post_clr4", {28'd0, stall_cnt4}, 32'd1);

    @(posedge CLK);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
